fifo_wr_arbiter: RTL and testbench

Write-domain arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters. It grants ownership round-robin, with a bounded burst per grant. It drives wr_en/data_in directly into the FIFO and honours full, so a write is never issued into a full FIFO. An optional half-full throttle shortens bursts to one word while the FIFO is at least half full.

---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write domain.
// Bounded bursts per grant, full-safe writes, optional half-full throttle.
module fifo_wr_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int BURST_LEN        = 4,
    parameter int THROTTLE_ON_HALF = 1,
    parameter int ID_WIDTH         = $clog2(NUM_REQ)
) (
    input  logic                          clk_wr,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          full,
    input  logic                          half,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t              state, state_n;
    logic [ID_WIDTH-1:0] owner, owner_n;
    logic [ID_WIDTH-1:0] last_owner, last_n;
    logic [CW-1:0]       burst_cnt, cnt_n;

    logic                  req_own;
    logic [DATA_WIDTH-1:0] data_sel;
    logic [CW-1:0]         lim;
    logic                  last_word;
    logic                  rel;

    function automatic logic [ID_WIDTH-1:0] next_id(
        input logic [ID_WIDTH-1:0] x
    );
        return (x == ID_WIDTH'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // First requester after 'last', wrapping; 'last' itself is checked last.
    function automatic logic [ID_WIDTH-1:0] rr_pick(
        input logic [ID_WIDTH-1:0] last,
        input logic [NUM_REQ-1:0]  r
    );
        logic [ID_WIDTH-1:0] c;
        logic [ID_WIDTH-1:0] p;
        logic                found;
        c     = next_id(last);
        p     = c;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && r[c]) begin
                p     = c;
                found = 1'b1;
            end
            c = next_id(c);
        end
        return p;
    endfunction

    always_comb begin
        req_own  = 1'b0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == ID_WIDTH'(i)) begin
                req_own  = req[i];
                data_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy     = (state == OWN);
    assign wr_en    = busy & req_own & ~full;
    assign ack      = wr_en ? (NUM_REQ'(1) << owner) : '0;
    assign data_in  = busy ? data_sel : '0;
    assign grant_id = busy ? owner : '0;

    assign lim = ((THROTTLE_ON_HALF != 0) && half) ? CW'(1) : CW'(BURST_LEN);
    // '>=' also covers a throttle that engaged mid-burst
    assign last_word = (burst_cnt >= lim - CW'(1));

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_owner;
        cnt_n   = burst_cnt;
        rel     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n = OWN;
                    owner_n = rr_pick(last_owner, req);
                    cnt_n   = '0;
                end
            end
            OWN: begin
                if (!req_own) begin
                    rel = 1'b1;
                end else if (wr_en) begin
                    if (last_word) rel = 1'b1;
                    else cnt_n = burst_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // A dropped owner request is already absent from req.
        if (rel) begin
            last_n = owner;
            cnt_n  = '0;
            if (|req) begin
                state_n = OWN;
                owner_n = rr_pick(owner, req);
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
            burst_cnt  <= cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized
// traffic against a queue-based round-robin reference model.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int BL  = 4;
    localparam int THR = 1;
    localparam int IW  = 2;

    logic            clk_wr = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            full;
    logic            half;
    logic            wr_en;
    logic [DW-1:0]   data_in;
    logic [IW-1:0]   grant_id;
    logic            busy;

    fifo_wr_arbiter #(
        .NUM_REQ(N),
        .DATA_WIDTH(DW),
        .BURST_LEN(BL),
        .THROTTLE_ON_HALF(THR),
        .ID_WIDTH(IW)
    ) dut (
        .clk_wr(clk_wr),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .full(full),
        .half(half),
        .wr_en(wr_en),
        .data_in(data_in),
        .grant_id(grant_id),
        .busy(busy)
    );

    always #5 clk_wr = ~clk_wr;

    logic [15:0] obs;
    logic [15:0] e_vec;
    assign obs = {wr_en, ack, data_in, grant_id, busy};

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[N][$];
    int            ack_log[$];
    logic [N-1:0]  ack_s;

    // reference model: who owns the port and how many words it has written
    bit m_own;
    int m_owner;
    int m_last;
    int m_done;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (q[i].size() > 0);
            req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    function automatic int rr(input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic calc_exp();
        logic          w;
        logic [N-1:0]  a;
        logic [DW-1:0] d;
        logic [IW-1:0] g;
        w = m_own && req[m_owner] && !full;
        a = '0;
        if (w) a[m_owner] = 1'b1;
        d = m_own ? req_data[m_owner*DW +: DW] : '0;
        g = m_own ? IW'(m_owner) : '0;
        e_vec = {w, a, d, g, m_own};
    endtask

    task automatic model_step();
        int lim;
        bit rel;
        rel = 1'b0;
        lim = (THR != 0 && half) ? 1 : BL;
        if (!m_own) begin
            if (req != 0) begin
                m_own   = 1'b1;
                m_owner = rr(m_last);
                m_done  = 0;
            end
        end else if (!req[m_owner]) begin
            rel = 1'b1;
        end else if (!full) begin
            m_done++;
            if (m_done >= lim) rel = 1'b1;
        end
        if (rel) begin
            m_last = m_owner;
            m_done = 0;
            if (req != 0) m_owner = rr(m_last);
            else m_own = 1'b0;
        end
    endtask

    task automatic sample();
        drive();
        calc_exp();
        @(negedge clk_wr);
    endtask

    task automatic advance();
        logic [DW-1:0] tmp;
        ack_s = ack;
        @(posedge clk_wr);
        model_step();
        for (int i = 0; i < N; i++) begin
            if (ack_s[i]) begin
                tmp = q[i].pop_front();
                ack_log.push_back(i);
            end
        end
        #1;
    endtask

    task automatic model_reset();
        m_own   = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_done  = 0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        full = 1'b0;
        half = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        ack_log.delete();
        drive();
        model_reset();
        @(posedge clk_wr);
        #1;
        rst = 1'b0;
    endtask

    // one nibble per acked index, stored as index+1 so zeros mean "empty"
    function automatic logic [127:0] pack_log();
        logic [127:0] v;
        v = '0;
        foreach (ack_log[k]) v = {v[123:0], 4'(ack_log[k] + 1)};
        return v;
    endfunction

    task automatic test_reset();
        rst  = 1'b1;
        full = 1'b0;
        half = 1'b0;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            q[i].push_back(8'(160 + i));
        end
        drive();
        repeat (2) begin
            @(negedge clk_wr);
            checks++;
            if (obs !== 16'h0000) begin
                errors++;
                $display("FAIL reset_outputs got=%h exp=0000", obs);
            end
        end
        do_reset();
    endtask

    task automatic test_single_stream();
        logic [9:0] wr_hist;
        logic [9:0] busy_hist;
        do_reset();
        for (int w = 0; w < 6; w++) q[0].push_back(8'(16 + w));
        for (int c = 0; c < 10; c++) begin
            sample();
            wr_hist[c]   = wr_en;
            busy_hist[c] = busy;
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL single c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            advance();
        end
        checks++;
        if (wr_hist !== 10'b0001111110) begin
            errors++;
            $display("FAIL single_wr got=%b exp=%b", wr_hist, 10'b0001111110);
        end
        checks++;
        if (busy_hist !== 10'b0011111110) begin
            errors++;
            $display("FAIL single_busy got=%b exp=%b", busy_hist, 10'b0011111110);
        end
        checks++;
        if (pack_log() !== 128'h111111) begin
            errors++;
            $display("FAIL single_log got=%h exp=111111", pack_log());
        end
    endtask

    task automatic test_round_robin();
        int nwr;
        do_reset();
        nwr = 0;
        for (int i = 0; i < N; i++)
            for (int w = 0; w < 8; w++) q[i].push_back(8'(i * 16 + w));
        for (int c = 0; c < 18; c++) begin
            sample();
            if (wr_en) nwr++;
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL rr c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            advance();
        end
        checks++;
        if (nwr != 17) begin
            errors++;
            $display("FAIL rr_no_bubble got=%0d exp=17", nwr);
        end
        checks++;
        if (pack_log() !== 128'h11112222333344441) begin
            errors++;
            $display("FAIL rr_order got=%h exp=11112222333344441", pack_log());
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int w = 0; w < 6; w++) q[1].push_back(8'(32 + w));
        for (int w = 0; w < 4; w++) q[2].push_back(8'(48 + w));
        for (int c = 0; c < 13; c++) begin
            full = (c >= 3 && c < 8);
            sample();
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL stall c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            advance();
        end
        full = 1'b0;
        checks++;
        if (pack_log() !== 128'h2222333) begin
            errors++;
            $display("FAIL stall_log got=%h exp=2222333", pack_log());
        end
    endtask

    task automatic test_throttle();
        do_reset();
        for (int w = 0; w < 10; w++) begin
            q[0].push_back(8'(64 + w));
            q[1].push_back(8'(80 + w));
            q[3].push_back(8'(112 + w));
        end
        for (int c = 0; c < 15; c++) begin
            half = (c <= 6);
            sample();
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL throttle c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            advance();
        end
        half = 1'b0;
        checks++;
        if (pack_log() !== 128'h12412411112222) begin
            errors++;
            $display("FAIL throttle_log got=%h exp=12412411112222", pack_log());
        end
    endtask

    task automatic test_drop();
        logic [IW-1:0] g2;
        logic [IW-1:0] g3;
        logic          w2;
        do_reset();
        q[2].push_back(8'h55);
        g2 = '0;
        g3 = '0;
        w2 = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c == 1)
                for (int w = 0; w < 6; w++) q[0].push_back(8'(144 + w));
            if (c == 3)
                for (int w = 0; w < 4; w++) q[2].push_back(8'(160 + w));
            sample();
            if (c == 2) begin
                g2 = grant_id;
                w2 = wr_en;
            end
            if (c == 3) g3 = grant_id;
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL drop c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            advance();
        end
        checks++;
        if (g2 !== 2'd2 || w2 !== 1'b0 || g3 !== 2'd0) begin
            errors++;
            $display("FAIL drop_regrant got=g%0d/w%b/g%0d exp=g2/w0/g0", g2, w2, g3);
        end
        checks++;
        if (pack_log() !== 128'h311113333) begin
            errors++;
            $display("FAIL drop_log got=%h exp=311113333", pack_log());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int w = 0; w < 6; w++) q[3].push_back(8'(192 + w));
        for (int c = 0; c < 3; c++) begin
            sample();
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL rstmid c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            advance();
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_async got=%h exp=0000", obs);
        end
        @(posedge clk_wr);
        #1;
        rst = 1'b0;
        model_reset();
        ack_log.delete();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            for (int w = 0; w < 4; w++) q[i].push_back(8'(208 + i * 4 + w));
        end
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL rstmid_post c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            advance();
        end
        checks++;
        if (pack_log() !== 128'h1111) begin
            errors++;
            $display("FAIL rstmid_log got=%h exp=1111", pack_log());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int n;
                    n = $urandom_range(1, 5);
                    for (int w = 0; w < n; w++) q[i].push_back(8'($urandom));
                end
            end
            full = ($urandom_range(0, 3) == 0);
            half = ($urandom_range(0, 2) == 0);
            sample();
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL random c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            advance();
        end
        full = 1'b0;
        half = 1'b0;
    endtask

    initial begin
        req      = '0;
        req_data = '0;
        full     = 1'b0;
        half     = 1'b0;
        model_reset();
        test_reset();
        test_single_stream();
        test_round_robin();
        test_full_stall();
        test_throttle();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
